// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: default memory depth,
// FSM state encoding and read-return owner tag encoding.
package dmem_arbiter_pkg;

  localparam int DMEM_WORDS_DEF = 4096;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } own_e;

endpackage

// File: rtl/dmem_rd_return.sv
// Read-return steering: remembers which port owns the read issued last
// cycle and routes the memory read data to that port only.
module dmem_rd_return
  import dmem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  rd_own,     // owner of a read granted this cycle
  input  logic        rd_zero,    // that read was out of range: return zero
  input  logic [31:0] mem_rdata,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata
);

  own_e        own_d, own_q;
  logic        zero_d, zero_q;
  logic [31:0] ret_data;

  // Next owner tag is simply the read issued this cycle
  always_comb begin
    own_d  = own_e'(rd_own);
    zero_d = rd_zero;
  end

  // Owner tag register; reset drops any pending return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_q  <= OWN_NONE;
      zero_q <= 1'b0;
    end else begin
      own_q  <= own_d;
      zero_q <= zero_d;
    end
  end

  // Steer returning data to the owning port; the other port reads zero
  always_comb begin
    ret_data   = zero_q ? 32'h0 : mem_rdata;
    cpu_rvalid = (own_q == OWN_CPU);
    dbg_rvalid = (own_q == OWN_DBG);
    cpu_rdata  = cpu_rvalid ? ret_data : 32'h0;
    dbg_rdata  = dbg_rvalid ? ret_data : 32'h0;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU has default priority, the debug port
// is guaranteed a slot after MAX_STREAK consecutive CPU wins, and a halt
// FSM blocks the CPU once its outstanding read has drained.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int MEM_WORDS  = DMEM_WORDS_DEF,
  parameter int MAX_STREAK = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cpu_req,
  input  logic [3:0]                   cpu_we,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [31:0]                  cpu_wdata,
  output logic                         cpu_gnt,
  output logic                         cpu_stall,
  output logic                         cpu_rvalid,
  output logic [31:0]                  cpu_rdata,
  input  logic                         dbg_req,
  input  logic [3:0]                   dbg_we,
  input  logic [ADDR_W-1:0]            dbg_addr,
  input  logic [31:0]                  dbg_wdata,
  output logic                         dbg_gnt,
  output logic                         dbg_rvalid,
  output logic [31:0]                  dbg_rdata,
  input  logic                         dbg_halt,
  output logic                         cpu_halted,
  output logic                         err_oob,
  output logic                         mem_en,
  output logic [3:0]                   mem_we,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
  output logic [31:0]                  mem_wdata,
  input  logic [31:0]                  mem_rdata
);

  localparam int                IDX_W    = $clog2(MEM_WORDS);
  localparam int                STREAK_W = $clog2(MAX_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);
  // First byte address past the end of memory
  localparam logic [ADDR_W-1:0] OOB_BASE = ADDR_W'(MEM_WORDS) << 2;

  arb_state_e            state_d, state_q;
  logic [STREAK_W-1:0]   streak_d, streak_q;
  logic                  err_d, err_q;
  logic                  cpu_req_v, dbg_req_v, run_prio, dbg_wins, gnt_any;
  logic [ADDR_W-1:0]     sel_addr;
  logic [3:0]            sel_we;
  logic [31:0]           sel_wdata;
  logic                  sel_oob;
  own_e                  rd_own;

  // Grant selection and memory-side drive (requests masked while in reset)
  always_comb begin
    cpu_req_v = cpu_req & rst;
    dbg_req_v = dbg_req & rst;
    // Halt falling in DRAIN/HALTED already restores normal priority
    run_prio  = (state_q == ST_RUN) || !dbg_halt;
    dbg_wins  = dbg_req_v && (streak_q == STREAK_MAX);
    if (run_prio) begin
      cpu_gnt = cpu_req_v & ~dbg_wins;
      dbg_gnt = dbg_req_v & ~cpu_gnt;
    end else begin
      cpu_gnt = 1'b0;
      dbg_gnt = dbg_req_v;
    end
    cpu_stall = cpu_req_v & ~cpu_gnt;
    gnt_any   = cpu_gnt | dbg_gnt;
    sel_addr  = dbg_gnt ? dbg_addr  : cpu_addr;
    sel_we    = dbg_gnt ? dbg_we    : cpu_we;
    sel_wdata = dbg_gnt ? dbg_wdata : cpu_wdata;
    sel_oob   = (sel_addr >= OOB_BASE);
    mem_en    = gnt_any & ~sel_oob;
    mem_we    = gnt_any ? sel_we : 4'h0;
    mem_addr  = gnt_any ? sel_addr[IDX_W+1:2] : '0;
    mem_wdata = gnt_any ? sel_wdata : 32'h0;
    rd_own    = OWN_NONE;
    if (gnt_any && (sel_we == 4'h0)) rd_own = dbg_gnt ? OWN_DBG : OWN_CPU;
    err_d     = gnt_any & sel_oob;
  end

  // Streak counter and halt FSM next-state
  always_comb begin
    streak_d = streak_q;
    if (!dbg_req_v || dbg_gnt)
      streak_d = '0;
    else if (cpu_gnt && (streak_q != STREAK_MAX))
      streak_d = streak_q + STREAK_W'(1);
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (dbg_halt) state_d = ST_DRAIN;
      // A CPU read issued before entering DRAIN returns in this cycle
      ST_DRAIN:  if (!dbg_halt) state_d = ST_RUN;
                 else if (rd_own != OWN_CPU) state_d = ST_HALTED;
      ST_HALTED: if (!dbg_halt) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      streak_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      err_q    <= err_d;
    end
  end

  // Status outputs
  always_comb begin
    cpu_halted = (state_q == ST_HALTED);
    err_oob    = err_q;
  end

  dmem_rd_return u_rd_return (
    .clk        (clk),
    .rst_n      (rst),
    .rd_own     (rd_own),
    .rd_zero    (sel_oob),
    .mem_rdata  (mem_rdata),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: behavioural memory, read-return scoreboard.
module tb_dmem_arbiter;

  localparam int MW = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, dbg_req, dbg_halt;
  logic [3:0]  cpu_we, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic        cpu_halted, err_oob, mem_en;
  logic [3:0]  mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  typedef struct {
    logic        port;   // 0 = cpu, 1 = dbg
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        exp_err;
  logic        exp_halted;
  logic [31:0] ref_mem [0:MW-1];
  logic [31:0] mem     [0:MW-1];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .MEM_WORDS(MW), .MAX_STREAK(8)) dut (
    .clk(clk), .rst(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .dbg_halt(dbg_halt), .cpu_halted(cpu_halted), .err_oob(err_oob),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEAD_BEEF;
    return (32'(i) * 32'h9E37_79B9) ^ 32'h0F0F_5A5A;
  endfunction

  // Behavioural synchronous memory, one-cycle read latency
  initial begin
    for (int i = 0; i < MW; i++) mem[i] = init_word(i);
    mem_rdata = 32'hCAFE_F00D;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we == 4'h0) mem_rdata <= mem[mem_addr];
        else for (int b = 0; b < 4; b++)
          if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic drive_cpu(input logic rq, input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd);
    cpu_req = rq; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
  endtask

  task automatic drive_dbg(input logic rq, input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd);
    dbg_req = rq; dbg_we = we; dbg_addr = a; dbg_wdata = wd;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".cpu_gnt"},    32'(cpu_gnt),    32'h0);
    chk({tag, ".cpu_stall"},  32'(cpu_stall),  32'h0);
    chk({tag, ".cpu_rvalid"}, 32'(cpu_rvalid), 32'h0);
    chk({tag, ".cpu_rdata"},  cpu_rdata,       32'h0);
    chk({tag, ".dbg_gnt"},    32'(dbg_gnt),    32'h0);
    chk({tag, ".dbg_rvalid"}, 32'(dbg_rvalid), 32'h0);
    chk({tag, ".dbg_rdata"},  dbg_rdata,       32'h0);
    chk({tag, ".mem_en"},     32'(mem_en),     32'h0);
    chk({tag, ".mem_we"},     32'(mem_we),     32'h0);
    chk({tag, ".mem_addr"},   32'(mem_addr),   32'h0);
    chk({tag, ".mem_wdata"},  mem_wdata,       32'h0);
    chk({tag, ".err_oob"},    32'(err_oob),    32'h0);
    chk({tag, ".cpu_halted"}, 32'(cpu_halted), 32'h0);
  endtask

  // One cycle: inputs already driven; check this cycle's grants and the
  // returns of last cycle's reads, then queue this cycle's expected returns.
  task automatic step(input string tag, input logic ecg, input logic edg);
    exp_t        e;
    logic        exp_crv, exp_drv, s_oob, exp_en;
    logic [31:0] exp_crd, exp_drd, s_addr, s_wd;
    logic [3:0]  s_we;
    int          idx;
    @(negedge clk);
    exp_crv = 1'b0; exp_drv = 1'b0; exp_crd = 32'h0; exp_drd = 32'h0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.port) begin exp_drv = 1'b1; exp_drd = e.data; end
      else        begin exp_crv = 1'b1; exp_crd = e.data; end
    end
    chk({tag, ".cpu_gnt"},    32'(cpu_gnt),    32'(ecg));
    chk({tag, ".dbg_gnt"},    32'(dbg_gnt),    32'(edg));
    chk({tag, ".cpu_stall"},  32'(cpu_stall),  32'(cpu_req & ~ecg));
    chk({tag, ".cpu_rvalid"}, 32'(cpu_rvalid), 32'(exp_crv));
    chk({tag, ".cpu_rdata"},  cpu_rdata,       exp_crd);
    chk({tag, ".dbg_rvalid"}, 32'(dbg_rvalid), 32'(exp_drv));
    chk({tag, ".dbg_rdata"},  dbg_rdata,       exp_drd);
    chk({tag, ".err_oob"},    32'(err_oob),    32'(exp_err));
    chk({tag, ".cpu_halted"}, 32'(cpu_halted), 32'(exp_halted));
    s_addr = edg ? dbg_addr  : cpu_addr;
    s_we   = edg ? dbg_we    : cpu_we;
    s_wd   = edg ? dbg_wdata : cpu_wdata;
    s_oob  = (s_addr >= 32'h0000_4000);
    exp_en = (ecg | edg) & ~s_oob;
    chk({tag, ".mem_en"}, 32'(mem_en), 32'(exp_en));
    if (exp_en) begin
      chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(s_addr[13:2]));
      chk({tag, ".mem_we"},   32'(mem_we),   32'(s_we));
      if (s_we != 4'h0) chk({tag, ".mem_wdata"}, mem_wdata, s_wd);
    end
    exp_err = (ecg | edg) & s_oob;
    if (ecg | edg) begin
      idx = int'(s_addr[13:2]);
      if (s_we == 4'h0) begin
        e.port = edg;
        e.data = s_oob ? 32'h0 : ref_mem[idx];
        sb_q.push_back(e);
      end else if (!s_oob) begin
        for (int b = 0; b < 4; b++)
          if (s_we[b]) ref_mem[idx][8*b +: 8] = s_wd[8*b +: 8];
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < MW; i++) ref_mem[i] = init_word(i);
    exp_err = 1'b0; exp_halted = 1'b0;
    // Reset with requests active: every output must stay low
    rst_n = 1'b0; dbg_halt = 1'b1;
    drive_cpu(1'b1, 4'h0, 32'h10, 32'h0);
    drive_dbg(1'b1, 4'hF, 32'h40, 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1; dbg_halt = 1'b0;
    drive_cpu(1'b0, 4'h0, 32'h0, 32'h0);
    drive_dbg(1'b0, 4'h0, 32'h0, 32'h0);

    // Basic CPU read of word 4
    drive_cpu(1'b1, 4'h0, 32'h10, 32'h0);
    step("cpu_rd", 1'b1, 1'b0);
    drive_cpu(1'b0, 4'h0, 32'h0, 32'h0);
    step("cpu_rd_ret", 1'b0, 1'b0);

    // Both ports request: 8 CPU grants then one debug grant, repeating
    for (int k = 0; k < 18; k++) begin
      drive_cpu(1'b1, 4'h0, 32'(4 * k), 32'h0);
      drive_dbg(1'b1, 4'h0, 32'(4 * (200 + k)), 32'h0);
      step("streak", (k % 9) != 8, (k % 9) == 8);
    end
    drive_cpu(1'b0, 4'h0, 32'h0, 32'h0);
    drive_dbg(1'b0, 4'h0, 32'h0, 32'h0);
    step("streak_end", 1'b0, 1'b0);

    // Alternating single-port reads, one per cycle
    for (int k = 0; k < 8; k++) begin
      drive_cpu(k % 2 == 0, 4'h0, 32'(4 * (50 + k)), 32'h0);
      drive_dbg(k % 2 == 1, 4'h0, 32'(4 * (300 + k)), 32'h0);
      step("alt", k % 2 == 0, k % 2 == 1);
    end
    drive_cpu(1'b0, 4'h0, 32'h0, 32'h0);
    drive_dbg(1'b0, 4'h0, 32'h0, 32'h0);

    // Partial-byte CPU write, read back by debug port
    drive_cpu(1'b1, 4'b0011, 32'h44, 32'hAABB_CCDD);
    step("bwr", 1'b1, 1'b0);
    drive_cpu(1'b0, 4'h0, 32'h0, 32'h0);
    drive_dbg(1'b1, 4'h0, 32'h44, 32'h0);
    step("bwr_rd", 1'b0, 1'b1);
    drive_dbg(1'b0, 4'h0, 32'h0, 32'h0);
    step("bwr_ret", 1'b0, 1'b0);

    // Halt rises with a CPU read in the same cycle
    dbg_halt = 1'b1;
    drive_cpu(1'b1, 4'h0, 32'h10, 32'h0);
    step("halt_rise", 1'b1, 1'b0);
    drive_dbg(1'b1, 4'hF, 32'h40, 32'h1234_5678);
    step("drain", 1'b0, 1'b1);
    exp_halted = 1'b1;
    drive_dbg(1'b1, 4'h0, 32'h40, 32'h0);
    step("halted_rd", 1'b0, 1'b1);
    drive_dbg(1'b0, 4'h0, 32'h0, 32'h0);
    step("halted_idle", 1'b0, 1'b0);
    dbg_halt = 1'b0;
    drive_dbg(1'b1, 4'h0, 32'h80, 32'h0);
    step("halt_fall", 1'b1, 1'b0);
    exp_halted = 1'b0;
    drive_cpu(1'b0, 4'h0, 32'h0, 32'h0);
    drive_dbg(1'b0, 4'h0, 32'h0, 32'h0);
    step("run_again", 1'b0, 1'b0);

    // Out-of-range accesses
    drive_dbg(1'b1, 4'h0, 32'h0000_4000, 32'h0);
    step("oob_rd", 1'b0, 1'b1);
    drive_dbg(1'b0, 4'h0, 32'h0, 32'h0);
    drive_cpu(1'b1, 4'hF, 32'h0000_8000, 32'h5555_AAAA);
    step("oob_wr", 1'b1, 1'b0);
    drive_cpu(1'b0, 4'h0, 32'h0, 32'h0);
    step("oob_end", 1'b0, 1'b0);

    // Reset one cycle after a CPU read grant discards the return
    drive_cpu(1'b1, 4'h0, 32'h10, 32'h0);
    step("pre_rst", 1'b1, 1'b0);
    rst_n = 1'b0;
    sb_q.delete();
    exp_err = 1'b0;
    drive_dbg(1'b1, 4'h0, 32'h20, 32'h0);
    @(negedge clk);
    check_reset_outputs("mid_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_cpu(1'b0, 4'h0, 32'h0, 32'h0);
    drive_dbg(1'b0, 4'h0, 32'h0, 32'h0);
    step("post_rst", 1'b0, 1'b0);
    step("post_rst2", 1'b0, 1'b0);

    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
